// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, plus iterative shift-add
// MULTU and restoring DIVU that share one working datapath and write HI/LO.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_MFHI  = 4'b1011;
  localparam logic [3:0] OP_MFLO  = 4'b1100;

  state_t           r_state, w_nextState;
  logic [SHW-1:0]   r_count;
  logic [WIDTH-1:0] r_upper, r_lower, r_opnd;
  logic [WIDTH-1:0] r_result, r_hi, r_lo;
  logic             r_done, r_zero, r_ovf;

  logic             w_last;
  logic [WIDTH-1:0] w_sum, w_diff, w_aluRes;
  logic             w_aluOvf;
  logic [WIDTH:0]   w_mulSum, w_divShift, w_divTrial;
  logic             w_divOk;
  logic [WIDTH-1:0] w_nextUpper, w_nextLower;

  assign w_last = (r_count == SHW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start && ALUOperation == OP_MULTU)     w_nextState = MUL;
        else if (start && ALUOperation == OP_DIVU) w_nextState = DIV;
      end
      MUL, DIV: if (w_last) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  assign w_sum  = A + B;
  assign w_diff = A - B;

  always_comb begin
    w_aluRes = '0;
    w_aluOvf = 1'b0;
    case (ALUOperation)
      OP_AND: w_aluRes = A & B;
      OP_OR:  w_aluRes = A | B;
      OP_NOR: w_aluRes = ~(A | B);
      OP_ADD: begin
        w_aluRes = w_sum;
        w_aluOvf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_aluRes = w_diff;
        w_aluOvf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  w_aluRes = B << shamt;
      OP_SRL:  w_aluRes = B >> shamt;
      OP_SRA:  w_aluRes = $signed(B) >>> shamt;
      OP_SLT:  w_aluRes = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_MFHI: w_aluRes = r_hi;
      OP_MFLO: w_aluRes = r_lo;
      default: w_aluRes = '0;
    endcase
  end

  // Upper holds partial product / remainder, lower holds multiplier / quotient.
  assign w_mulSum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_opnd} : '0);
  assign w_divShift = {r_upper, r_lower[WIDTH-1]};
  assign w_divTrial = w_divShift - {1'b0, r_opnd};
  assign w_divOk    = ~w_divTrial[WIDTH];

  always_comb begin
    w_nextUpper = w_mulSum[WIDTH:1];
    w_nextLower = {w_mulSum[0], r_lower[WIDTH-1:1]};
    if (r_state == DIV) begin
      w_nextUpper = w_divOk ? w_divTrial[WIDTH-1:0] : w_divShift[WIDTH-1:0];
      w_nextLower = {r_lower[WIDTH-2:0], w_divOk};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count  <= '0;
      r_upper  <= '0;
      r_lower  <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_count <= '0;
          if (ALUOperation == OP_MULTU) begin
            r_upper <= '0;
            r_lower <= B;
            r_opnd  <= A;
          end else if (ALUOperation == OP_DIVU) begin
            r_upper <= '0;
            r_lower <= A;
            r_opnd  <= B;
          end else begin
            r_result <= w_aluRes;
            r_zero   <= (w_aluRes == '0);
            r_ovf    <= w_aluOvf;
            r_done   <= 1'b1;
          end
        end
      end else begin
        r_upper <= w_nextUpper;
        r_lower <= w_nextLower;
        r_count <= r_count + SHW'(1);
        if (w_last) begin
          r_hi     <= w_nextUpper;
          r_lo     <= w_nextLower;
          r_result <= w_nextLower;
          r_zero   <= (w_nextLower == '0);
          r_ovf    <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Overflow  = r_ovf;
  assign HI        = r_hi;
  assign LO        = r_lo;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand, result, HI and LO width (WIDTH >= 8).
REQ-002 Parameter SHW, default 5, SHALL set the shamt width (SHW = log2(WIDTH)).
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  in  1  request; an operation is accepted only when busy=0.
REQ-006 ALUOperation  in  4  opcode, sampled on acceptance.
REQ-007 A, B  in  WIDTH each  operands, sampled on acceptance.
REQ-008 shamt  in  SHW  shift amount, sampled on acceptance.
REQ-009 busy  out  1  high while a multi-cycle operation is in progress.
REQ-010 done  out  1  one-cycle pulse when ALUResult, Zero, Overflow, HI and LO are updated.
REQ-011 ALUResult  out  WIDTH  registered result.
REQ-012 Zero  out  1  registered; equals (ALUResult == 0).
REQ-013 Overflow  out  1  registered signed-overflow flag.
REQ-014 HI, LO  out  WIDTH each  multiply/divide result registers.

Function
REQ-015 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB, 0101 SLL (B<<shamt), 0110 SRL (B>>shamt), 0111 SRA (arithmetic B>>>shamt), 1000 SLT (signed A<B -> 1, else 0), 1001 MULTU, 1010 DIVU, 1011 MFHI, 1100 MFLO.
REQ-016 Opcodes 1101-1111 SHALL complete as single-cycle operations with ALUResult=0 and Overflow=0.
REQ-017 The FSM SHALL have states IDLE, MUL and DIV; busy=1 exactly in MUL and DIV.
REQ-018 Single-cycle opcodes accepted in IDLE SHALL update the outputs on the next edge and pulse done in that cycle (latency 1), with the FSM remaining in IDLE.
REQ-019 ADD/SUB SHALL be modulo 2^WIDTH; Overflow SHALL be set on two's-complement overflow for ADD/SUB only and cleared for every other opcode.
REQ-020 MULTU SHALL use an iterative shift-add unsigned multiply: IDLE->MUL, WIDTH iterations, then {HI,LO}=A*B (2*WIDTH bits) and done pulses; total latency WIDTH+1 cycles from the accepting edge.
REQ-021 DIVU SHALL use restoring unsigned division with the same latency as MULTU: LO=quotient, HI=remainder.
REQ-022 DIVU with B=0 SHALL produce LO=all ones and HI=A, with no flag and no early exit.
REQ-023 On MULTU/DIVU completion, ALUResult SHALL equal the new LO, Zero SHALL track it, and Overflow SHALL be 0.
REQ-024 MFHI/MFLO SHALL be single-cycle operations returning the current HI/LO.
REQ-025 HI and LO SHALL change only on MULTU/DIVU completion or reset.
REQ-026 start while busy=1 SHALL be ignored and not queued; inputs may change freely during busy.
REQ-027 start asserted in the same cycle as done, with busy=0 in that cycle, SHALL be accepted (back-to-back operation).
REQ-028 Between done pulses, all outputs SHALL hold their last values.
REQ-029 Shifts SHALL use only shamt; SLL/SRL/SRA with shamt=0 SHALL return B.

Reset
REQ-030 reset=0 at a clock edge SHALL force IDLE, busy=0, done=0, ALUResult=0, Zero=1, Overflow=0, HI=0 and LO=0.
REQ-031 Reset during MUL/DIV SHALL abort the operation without a done pulse, and HI/LO SHALL read 0.
REQ-032 start SHALL be ignored in any cycle where reset=0.

Verification
REQ-033 ADD A=32'h7FFFFFFF, B=1 -> next cycle: done=1, ALUResult=32'h80000000, Overflow=1, Zero=0.
REQ-034 SUB A=5, B=5 -> ALUResult=0, Zero=1, Overflow=0; SRA B=32'h80000000, shamt=4 -> ALUResult=32'hF8000000.
REQ-035 MULTU A=32'hFFFFFFFF, B=2 -> busy for 32 cycles, done at cycle 33; HI=1, LO=32'hFFFFFFFE, ALUResult=32'hFFFFFFFE.
REQ-036 DIVU A=100, B=7 -> LO=14, HI=2; DIVU A=9, B=0 -> LO=32'hFFFFFFFF, HI=9; then MFHI -> ALUResult=9 after 1 cycle.
REQ-037 start=1 repeatedly during MULTU busy with ADD opcodes -> exactly one done pulse, and the result is the multiply result.
REQ-038 reset=0 at cycle 10 of DIVU -> busy=0, no done pulse, HI=LO=0; the following ADD 1+2 -> ALUResult=3.
